// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared types and constants for the add_seq_64 block
//
// Contents:
//   state_t  FSM states IDLE / RUN / DONE
//   SLICE_W  width of the time-shared adder slice
//   clog2()  beat-counter width helper
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bounded loop so the function stays usable in synthesis contexts.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cla_16.sv
// rtl/cla_16.sv - two-level 16-bit carry-lookahead adder slice
//
// Ports:
//   a, b  in   16  operands
//   ci    in   1   carry in
//   s     out  16  sum
//   gg    out  1   group generate of the whole slice
//   gp    out  1   group propagate of the whole slice
module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        gg,
  output logic        gp
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // First level: 4-bit group generate/propagate.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int j = 0; j < 4; j++) begin
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      grp_p[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
    end
  end

  // Second level: group carries resolved directly from ci.
  always_comb begin
    gc[0] = ci;
    gc[1] = grp_g[0] | (grp_p[0] & ci);
    gc[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & ci);
    gc[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & ci);
  end

  assign gg = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
            | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
  assign gp = &grp_p;

  // Bit carries inside each group from that group's carry-in.
  always_comb begin
    c = '0;
    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
  end

  assign s = p ^ c;

endmodule

// File: rtl/add_seq_64.sv
// rtl/add_seq_64.sv - sequential adder/subtractor using one shared 16-bit CLA slice
//
// Build option: define ADD_SEQ_SUB_EN to honour in_sub (A-B); otherwise add only.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake
//   in_a, in_b  [W]      operands
//   in_sub, in_ci        subtract select, carry-in for addition
//   out_valid/out_ready  result handshake
//   out_s [W]            sum / difference
//   out_co, out_ovf      carry out of bit W-1, signed overflow
//   out_zero             result is zero
//   busy                 operation in progress or result pending
module add_seq_64
  import add_seq_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_s,
  output logic         out_co,
  output logic         out_ovf,
  output logic         out_zero,
  output logic         busy
);

  localparam int BEATS = W / SLICE_W;
  localparam int KW    = clog2(BEATS);
  localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

  if ((W % SLICE_W) != 0 || W < 32 || W > 128) begin : g_bad_w
    $error("add_seq_64: W must be a multiple of 16 in 32..128");
  end

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    s_q, s_d;
  logic            co_q, co_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic            accept;
  logic [W-1:0]    b_eff;
  logic            c_init;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] sum_slice;
  logic            slice_g;
  logic            slice_p;
  logic            c_out;
  logic            c_msb_in;

`ifdef ADD_SEQ_SUB_EN
  // Subtraction as A + ~B + 1.
  assign b_eff  = in_sub ? ~in_b : in_b;
  assign c_init = in_sub ? 1'b1 : in_ci;
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign b_eff  = in_b;
  assign c_init = in_ci;
`endif

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign a_slice = a_q[int'(k_q)*SLICE_W +: SLICE_W];
  assign b_slice = b_q[int'(k_q)*SLICE_W +: SLICE_W];

  cla_16 u_cla (
    .a  (a_slice),
    .b  (b_slice),
    .ci (carry_q),
    .s  (sum_slice),
    .gg (slice_g),
    .gp (slice_p)
  );

  assign c_out    = slice_g | (slice_p & carry_q);
  // Carry into the slice MSB recovered from the sum bit: s = a ^ b ^ c.
  assign c_msb_in = a_slice[SLICE_W-1] ^ b_slice[SLICE_W-1] ^ sum_slice[SLICE_W-1];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        s_d[int'(k_q)*SLICE_W +: SLICE_W] = sum_slice;
        carry_d = c_out;
        zero_d  = zero_q & (sum_slice == '0);
        k_d     = k_q + 1'b1;
        if (k_q == LAST_K) begin
          co_d    = c_out;
          ovf_d   = c_msb_in ^ c_out;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept only happens in IDLE or in DONE with out_ready; it overrides both.
    if (accept) begin
      a_d     = in_a;
      b_d     = b_eff;
      carry_d = c_init;
      k_d     = '0;
      zero_d  = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_s     = s_q;
  assign out_co    = co_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_add_seq_64.sv
// tb/tb_add_seq_64.sv - scoreboard bench for add_seq_64 at W=64
module tb_add_seq_64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_sub;
  logic        in_ci;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_s;
  logic        out_co;
  logic        out_ovf;
  logic        out_zero;
  logic        busy;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  add_seq_64 #(.W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_ci     (in_ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Caller is aligned 2 time units after a rising edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       input logic ci, input logic [63:0] es, input logic eco,
                       input logic eovf, input logic ez);
    bit done;
    exp_t e;
    in_a = a; in_b = b; in_sub = sub; in_ci = ci; in_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.s = es; e.co = eco; e.ovf = eovf; e.zero = ez; e.acc = cyc + 1;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) timeout("accept");
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) timeout("drain");
    @(posedge clk); #2;
  endtask

  // Monitor: latency on each rising out_valid, values every valid cycle,
  // in_ready low while a result is being held off.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && sb.size() == 0) begin
        chk("unexpected_valid", {63'd0, out_valid}, 64'd0);
      end else if (out_valid) begin
        if (!prev_valid) chk("latency", 64'(cyc - sb[0].acc), 64'd4);
        chk("out_s", out_s, sb[0].s);
        chk("out_co", {63'd0, out_co}, {63'd0, sb[0].co});
        chk("out_ovf", {63'd0, out_ovf}, {63'd0, sb[0].ovf});
        chk("out_zero", {63'd0, out_zero}, {63'd0, sb[0].zero});
        if (!out_ready) chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        else void'(sb.pop_front());
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_sub = 1'b0; in_ci = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_out_s", out_s, 64'd0);
    chk("rst_out_co", {63'd0, out_co}, 64'd0);
    chk("rst_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
    wait_drain();
    // Back-to-back run with out_ready held high.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
`ifdef ADD_SEQ_SUB_EN
    issue(64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
`else
    issue(64'd5, 64'd7, 1'b1, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0);
`endif
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1,
          64'h2222_2222_2222_2212, 1'b0, 1'b0, 1'b0);
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Hold a result for 10 cycles, then release with a new request waiting.
    out_ready = 1'b0;
    issue(64'd1, 64'd2, 1'b0, 1'b1, 64'd4, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) timeout("hold_valid");
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    out_ready = 1'b1;
    issue(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Abort during beat 2.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_out_s", out_s, 64'd0);
    chk("abort_out_co", {63'd0, out_co}, 64'd0);
    chk("abort_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("abort_out_zero", {63'd0, out_zero}, 64'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_busy_after", {63'd0, busy}, 64'd0);
    @(posedge clk); #2;
    issue(64'h0000_0000_0000_0010, 64'h0000_0000_0000_0020, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, 1'b0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
